// File: rtl/cl_axi_mstr_arb_pkg.sv
// rtl/cl_axi_mstr_arb_pkg.sv - shared types and AXI constants for the command arbiter
package cl_axi_mstr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_AW = 3'd1,
    ST_WR_W  = 3'd2,
    ST_WR_B  = 3'd3,
    ST_RD_AR = 3'd4,
    ST_RD_R  = 3'd5
  } state_e;

  localparam int         MAX_REQ        = 8;
  localparam int         REQ_IDX_W      = $clog2(MAX_REQ);
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/cl_axi_mstr_arb_rr.sv
// rtl/cl_axi_mstr_arb_rr.sv - round-robin picker: first request at or above ptr, wrapping
module cl_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin : pick
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cl_axi_mstr_arb.sv
// rtl/cl_axi_mstr_arb.sv - shares one 512-bit AXI4 master between single-beat 32-bit requesters
module cl_axi_mstr_arb
  import cl_axi_mstr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_rd_wrb,
  input  logic [NUM_REQ*64-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    cpl_valid,
  output logic [31:0]           cpl_rdata,
  output logic [1:0]            cpl_resp,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [63:0]           m_awaddr,
  output logic [ID_W-1:0]       m_awid,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [511:0]          m_wdata,
  output logic [63:0]           m_wstrb,
  output logic                  m_wlast,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  input  logic [ID_W-1:0]       m_bid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [63:0]           m_araddr,
  output logic [ID_W-1:0]       m_arid,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [511:0]          m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic [ID_W-1:0]       m_rid,
  input  logic                  m_rlast
);

  localparam int IDX_W = REQ_IDX_W;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic                 rd_wrb_q, rd_wrb_d;
  logic [63:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [NUM_REQ-1:0]   cpl_valid_q, cpl_valid_d;
  logic [31:0]          cpl_rdata_q, cpl_rdata_d;
  logic [1:0]           cpl_resp_q, cpl_resp_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 sel_rd_wrb;
  logic [63:0]          sel_addr;
  logic [31:0]          sel_wdata;
  logic [NUM_REQ-1:0]   gidx_onehot;
  logic [8:0]           lane_bits;
  logic [511:0]         r_shifted;
  logic                 unused_sink;

  cl_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_rd_wrb = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_rd_wrb = req_rd_wrb[i];
        sel_addr   = req_addr[i*64 +: 64];
        sel_wdata  = req_wdata[i*32 +: 32];
      end
    end
  end

  // The 32-bit word sits at byte lane addr[5:0] of the 512-bit bus in both directions.
  assign lane_bits   = {addr_q[5:0], 3'b000};
  assign r_shifted   = m_rdata >> lane_bits;
  assign gidx_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    rd_wrb_d    = rd_wrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpl_valid_d = '0;
    cpl_rdata_d = cpl_rdata_q;
    cpl_resp_d  = cpl_resp_q;
    req_ready   = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          gidx_d    = arb_idx;
          rd_wrb_d  = sel_rd_wrb;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          ptr_d     = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
          state_d   = sel_rd_wrb ? ST_RD_AR : ST_WR_AW;
        end
      end
      ST_WR_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_d = ST_WR_W;
      end
      ST_WR_W: begin
        m_wvalid = 1'b1;
        if (m_wready) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          state_d     = ST_IDLE;
          cpl_valid_d = gidx_onehot;
          cpl_resp_d  = m_bresp;
          cpl_rdata_d = '0;
        end
      end
      ST_RD_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          state_d     = ST_IDLE;
          cpl_valid_d = gidx_onehot;
          cpl_resp_d  = m_rresp;
          cpl_rdata_d = r_shifted[31:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      rd_wrb_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpl_valid_q <= '0;
      cpl_rdata_q <= '0;
      cpl_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      rd_wrb_q    <= rd_wrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_rdata_q <= cpl_rdata_d;
      cpl_resp_q  <= cpl_resp_d;
    end
  end

  assign cpl_valid = cpl_valid_q;
  assign cpl_rdata = cpl_rdata_q;
  assign cpl_resp  = cpl_resp_q;

  assign m_awaddr = addr_q;
  assign m_awid   = ID_W'(gidx_q);
  assign m_awlen  = AXI_LEN_SINGLE;
  assign m_awsize = AXI_SIZE_4B;
  assign m_wdata  = {480'b0, wdata_q} << lane_bits;
  assign m_wstrb  = 64'hF << addr_q[5:0];
  assign m_wlast  = (state_q == ST_WR_W);
  assign m_araddr = addr_q;
  assign m_arid   = ID_W'(gidx_q);
  assign m_arlen  = AXI_LEN_SINGLE;
  assign m_arsize = AXI_SIZE_4B;

  // Response IDs and rlast carry no information with a single outstanding single-beat command.
  assign unused_sink = ^{m_bid, m_rid, m_rlast, r_shifted[511:32], rd_wrb_q};

endmodule
